// File: rtl/mul_unit_a_pkg.sv
// Shared constants and FSM encoding for the mul_unit_a partial-product generator.
// MUL_FAST_EN selects the three-multiplier single-cycle variant.
package mul_unit_a_pkg;

  localparam int unsigned BW_MUL = 96;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    DONE = 3'd4
  } state_t;

`ifdef MUL_FAST_EN
  localparam int unsigned LATENCY = 2;
`else
  localparam int unsigned LATENCY = 4;
`endif

endpackage

// File: rtl/mul_unit_a_if.sv
// EX-stage handshake and result bus between the pipeline and mul_unit_a.
interface mul_unit_a_if;
  import mul_unit_a_pkg::*;

  logic              start;
  logic              flush;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [BW_MUL-1:0] half_Result;
  logic              valid;
  logic              busy;
  logic              stall;

  modport master (
    output start, flush, op_a, op_b,
    input  half_Result, valid, busy, stall
  );

  modport slave (
    input  start, flush, op_a, op_b,
    output half_Result, valid, busy, stall
  );
endinterface

// File: rtl/mul_unit_a_mul16.sv
// Combinational unsigned 16x16 -> 32 multiplier used by mul_unit_a.
module mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/mul_unit_a.sv
// Partial-product generator for MIPS mul: produces {p2, p1, p0} for the MEM-stage combiner.
// Define MUL_FAST_EN for three parallel multipliers and a single compute state.
module mul_unit_a #(
  parameter int unsigned BW_MUL = mul_unit_a_pkg::BW_MUL
) (
  input  logic          clk,
  input  logic          rst,
  mul_unit_a_if.slave   bus
);
  import mul_unit_a_pkg::*;

  state_t            state, next_state;
  logic [31:0]       a_q, b_q;
  logic [BW_MUL-1:0] result_q;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: if (bus.start) next_state = P0;
`ifdef MUL_FAST_EN
      P0:   next_state = DONE;
`else
      P0:   next_state = P1;
      P1:   next_state = P2;
      P2:   next_state = DONE;
`endif
      DONE: next_state = bus.start ? P0 : IDLE;
      default: next_state = IDLE;
    endcase
    // Flush outranks start in every state, including a back-to-back restart from DONE.
    if (bus.flush) next_state = IDLE;
    accept = (state == IDLE || state == DONE) && bus.start && !bus.flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= bus.op_a;
      b_q <= bus.op_b;
    end
  end

`ifdef MUL_FAST_EN
  logic [31:0] prod0, prod1, prod2;

  mul16 u_mul0 (.a(a_q[15:0]),  .b(b_q[15:0]),  .p(prod0));
  mul16 u_mul1 (.a(a_q[31:16]), .b(b_q[15:0]),  .p(prod1));
  mul16 u_mul2 (.a(a_q[15:0]),  .b(b_q[31:16]), .p(prod2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           result_q <= '0;
    else if (state == P0 && !bus.flush) result_q <= {prod2, prod1, prod0};
  end

  assign bus.stall = !rst && accept;
`else
  logic [15:0] mul_a, mul_b;
  logic [31:0] prod;

  // Operand-select mux feeding the single shared multiplier.
  always_comb begin
    mul_a = a_q[15:0];
    mul_b = b_q[15:0];
    unique case (state)
      P1:      begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
      P2:      begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
      default: begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
    endcase
  end

  mul16 u_mul (.a(mul_a), .b(mul_b), .p(prod));

  // A flushed instruction leaves the previous contents untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (!bus.flush) begin
      unique case (state)
        P0:      result_q[31:0]  <= prod;
        P1:      result_q[63:32] <= prod;
        P2:      result_q[95:64] <= prod;
        default: ;
      endcase
    end
  end

  assign bus.stall = !rst && (bus.busy || accept);
`endif

  assign bus.half_Result = result_q;
  assign bus.valid       = (state == DONE);
  assign bus.busy        = (state == P0) || (state == P1) || (state == P2);

endmodule

// File: tb/tb_mul_unit_a.sv
// Scoreboard bench for mul_unit_a: directed multiplies, back-to-back issue, flush and reset.
module tb_mul_unit_a;

`ifdef MUL_FAST_EN
  localparam int LAT   = 2;
  localparam int STALL = 1;
`else
  localparam int LAT   = 4;
  localparam int STALL = 4;
`endif

  typedef struct packed {
    logic [95:0] res;
    logic [31:0] comb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   valid_seen = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];

  mul_unit_a_if bus();

  mul_unit_a #(.BW_MUL(96)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] combine(input logic [95:0] r);
    return r[31:0] + ((r[63:32] + r[95:64]) << 16);
  endfunction

  // Monitor: every valid cycle pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got=%0h", bus.half_Result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("half_Result", bus.half_Result, e.res);
        chk("combined", 96'(combine(bus.half_Result)), 96'(e.comb));
      end
    end
  end

  always @(negedge clk) if (bus.stall) stall_cnt++;

  task automatic push(input logic [95:0] r, input logic [31:0] c);
    exp_t e;
    e.res  = r;
    e.comb = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int target, input string name, output int cyc);
    cyc = 0;
    while (valid_seen < target && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (valid_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=%0d valids exp=%0d", name, valid_seen, target);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
  endtask

  initial begin
    int cyc;
    int tgt;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_result", bus.half_Result, 96'd0);
    chk("rst_valid",  96'(bus.valid), 96'd0);
    chk("rst_stall",  96'(bus.stall), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_result", bus.half_Result, 96'd0);
    chk("idle_valid",  96'(bus.valid), 96'd0);
    chk("idle_stall",  96'(bus.stall), 96'd0);

    // Basic 3 x 4
    issue(32'd3, 32'd4);
    push({32'd0, 32'd0, 32'h0000000C}, 32'd12);
    stall_cnt = 0;
    #1 chk("stall_start_cycle", 96'(bus.stall), 96'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    tgt = valid_seen + 1;
    wait_valid(tgt, "basic", cyc);
    chk("basic_latency", 96'(cyc), 96'(LAT));
    chk("basic_stall_cycles", 96'(stall_cnt), 96'(STALL));
    @(posedge clk); #1;
    chk("valid_one_cycle", 96'(bus.valid), 96'd0);

    // Split halves; operands change after acceptance
    issue(32'h00010002, 32'h00030004);
    push({32'd6, 32'd4, 32'd8}, 32'h000A0008);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op_a  = 32'hDEADBEEF;
    bus.op_b  = 32'h12345678;
    tgt = valid_seen + 1;
    wait_valid(tgt, "split", cyc);

    // All-ones operands
    issue(32'hFFFFFFFF, 32'hFFFFFFFF);
    push({32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001}, 32'h00000001);
    @(posedge clk); #1;
    bus.start = 1'b0;
    tgt = valid_seen + 1;
    wait_valid(tgt, "ones", cyc);

    // Back-to-back with start held high
    issue(32'd3, 32'd4);
    push({32'd0, 32'd0, 32'd12}, 32'd12);
    push({32'd0, 32'd0, 32'd30}, 32'd30);
    @(posedge clk); #1;
    bus.op_a = 32'd5;
    bus.op_b = 32'd6;
    tgt = valid_seen + 1;
    wait_valid(tgt, "b2b_first", cyc);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_no_idle_busy", 96'(bus.busy), 96'd1);
    tgt = valid_seen + 1;
    wait_valid(tgt, "b2b_second", cyc);
    chk("b2b_spacing", 96'(cyc), 96'(LAT));

    // Flush mid-computation: no valid may follow
    @(posedge clk); #1;
    issue(32'd7, 32'd9);
    @(posedge clk); #1;
    bus.start = 1'b0;
`ifndef MUL_FAST_EN
    @(posedge clk); #1;
`endif
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 96'(bus.busy), 96'd0);
    tgt = valid_seen;
    repeat (6) @(posedge clk);
    #1 chk("flush_no_valid", 96'(valid_seen), 96'(tgt));

    // start+flush in IDLE is rejected
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1 chk("start_flush_stall", 96'(bus.stall), 96'd0);
    @(posedge clk); #1;
    chk("start_flush_busy", 96'(bus.busy), 96'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;

    // Asynchronous reset mid-computation
    issue(32'd11, 32'd13);
    @(posedge clk); #1;
    bus.start = 1'b0;
`ifndef MUL_FAST_EN
    repeat (2) @(posedge clk);
    #1;
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_result", bus.half_Result, 96'd0);
    chk("arst_valid",  96'(bus.valid), 96'd0);
    chk("arst_busy",   96'(bus.busy), 96'd0);
    chk("arst_stall",  96'(bus.stall), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("arst_no_valid", 96'(valid_seen), 96'(tgt));

    chk("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_unit_a.md
# mul_unit_a

Execute-stage partial-product generator for the 32-bit MIPS `mul` instruction. It sits directly upstream of the memory stage's partial-sum combiner. It captures two 32-bit operands and produces the packed 96-bit `half_Result` = {p2, p1, p0}. The memory stage reduces that bus to the low 32 bits of the product as p0 + ((p1 + p2) << 16). A single shared 16×16 multiplier is time-multiplexed over three cycles, and the block stalls the front of the pipeline while it works.

## Interface
- `BW_MUL`, default 96: width of `half_Result`. Fixed at 3×32; any other value is unsupported.
- `clk` input, 1: pipeline clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `start` input, 1: EX holds a `mul` instruction with operands valid.
- `flush` input, 1: branch/jump squash of the EX instruction.
- `op_a` input, 32: multiplicand (busA).
- `op_b` input, 32: multiplier (busB).
- `half_Result` output, `BW_MUL`: {p2[31:0], p1[31:0], p0[31:0]}, registered.
- `valid` output, 1: `half_Result` is complete for the current `mul`.
- `busy` output, 1: FSM is in a compute state.
- `stall` output, 1: freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.

## Operation
- Products are unsigned 16×16 → 32 bits. The low 32 bits of the product are sign-agnostic, so there are no signed/unsigned variants.
  - p0 = op_a[15:0] × op_b[15:0]
  - p1 = op_a[31:16] × op_b[15:0]
  - p2 = op_a[15:0] × op_b[31:16]
  - op_a[31:16] × op_b[31:16] is never computed.
- Operands are latched into internal registers on acceptance. Later changes on `op_a`/`op_b` are ignored.
- FSM states are IDLE, P0, P1, P2, DONE.
  - IDLE: if `start` and not `flush`, latch operands, go to P0.
  - P0: shared multiplier computes p0, registered into `half_Result[31:0]`; go to P1.
  - P1: p1 into `[63:32]`; go to P2.
  - P2: p2 into `[95:64]`; go to DONE.
  - DONE: `valid`=1. If `start` (back-to-back `mul`), latch new operands and go to P0; otherwise go to IDLE.
- `flush` in any state forces IDLE on the next edge and deasserts `valid`. It has priority over `start`. `half_Result` keeps its stale contents.
- `start` while busy (P0–P2) is ignored.
- `busy` = state ∈ {P0, P1, P2}.
- `stall` = busy | (state ∈ {IDLE, DONE} & start & ~flush). It is combinational, so the pipeline freezes in the same cycle the `mul` is presented.

## Timing
- Reset values: state IDLE, `half_Result` 0, `valid` 0, `busy` 0, `stall` 0. Operand registers are 0.
- Latency: `start` accepted at edge T0. `valid` is high during the cycle after edge T3, which is 4 cycles after `start`.
- `stall` is high for cycles T0..T2+1, i.e. from the `start` cycle up to but excluding the DONE cycle. In DONE, `stall` is low, and the `mul` and `half_Result` advance into EX/MEM on the next edge.
- `valid` is high for exactly one cycle per accepted `mul`.
- Back-to-back `mul`: DONE goes straight to P0, so throughput is one `mul` per 4 cycles.
- `rst` asserted mid-operation: outputs drop to reset values immediately, without waiting for a clock edge.

## Configuration
- `MUL_FAST_EN` defined:
  - Three parallel 16×16 multipliers; P0/P1/P2 collapse into one state.
  - `start` accepted at T0 gives `valid` in the cycle after T1.
  - `stall` is high only in the `start` cycle.
  - DONE semantics and flush behaviour are unchanged.
- `MUL_FAST_EN` undefined: the shared single multiplier with three compute states, as described above.

## Structure
- Shared package holds:
  - `BW_MUL` = 96.
  - The FSM state encoding: IDLE=0, P0=1, P1=2, P2=3, DONE=4, 3-bit.
  - A latency constant, 4 or 2 depending on `MUL_FAST_EN`.
- One sub-module: `mul16`, a combinational unsigned 16×16 → 32 multiplier. It is instantiated once normally and three times under `MUL_FAST_EN`.
- The operand-select mux and FSM stay in the top level.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `half_Result`=0, `valid`=0, `stall`=0. Release `rst` → outputs unchanged until `start`.
- Basic: `op_a`=3, `op_b`=4, `start` pulse → `valid` after 4 cycles. `half_Result`={0, 0, 0x0000000C}; combined result 12. `stall` high for exactly 4 cycles.
- Split halves: `op_a`=0x00010002, `op_b`=0x00030004 → `half_Result`={6, 4, 8}; combined 0x000A0008. Change operands during P0 → result unchanged.
- Overflow operands: `op_a`=`op_b`=0xFFFFFFFF → p0=0xFFFE0001, p1=p2=0xFFFE0001; combined low 32 bits = 0x00000001.
- Back-to-back: `start` held high for two `mul`s (3×4, then 5×6) → `valid` pulses 4 cycles apart, with p0=12 then p0=30, and no idle cycle between them.
- Flush/priority: `flush` asserted in P1 → next state IDLE, `valid` never asserts. `start`+`flush` in IDLE → not accepted, `stall`=0. `rst` pulsed in P2 → immediate reset values.
